// File: rtl/mc_cu_if.sv
// mc_cu_if: memory-port handshake between the multicycle control unit and the shared I/D memory
//   mem_req   request an access this cycle
//   mem_write access is a write
//   iord      0 = address from PC, 1 = address from ALUOut
//   mem_ready memory completes the access this cycle
interface mc_cu_if;
   logic mem_req;
   logic mem_write;
   logic iord;
   logic mem_ready;
   modport master (output mem_req, mem_write, iord, input mem_ready);
   modport slave (input mem_req, mem_write, iord, output mem_ready);
endinterface

// File: rtl/mc_cu.sv
// mc_cu: multicycle MIPS control unit sequencing fetch/decode/execute/memory/write-back
//   clk, rst_n       clock, asynchronous active-low reset
//   op, zero         opcode from IR, ALU zero flag
//   mif (master)     memory request/write/iord out, mem_ready in
//   ir_write..reg_write  datapath controls, combinational from state/op/zero/mem_ready
//   state, retired   current state, completed-instruction count (registered)
//   illegal          unsupported opcode trapped (registered)
// Build option: define MC_CU_ILLEGAL_TRAP_EN to trap unsupported opcodes in HALT;
// otherwise they retire as NOPs.
module mc_cu #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       op,
   input  logic             zero,
   mc_cu_if.master          mif,
   output logic             ir_write,
   output logic             pc_en,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired,
   output logic             illegal
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
      MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9,
      ADDIWB = 4'd10, JUMP = 4'd11, HALT = 4'd12
   } st_t;
   st_t st, nx;
   logic mreq, mwr, io, pc_write, branch;
`ifdef MC_CU_ILLEGAL_TRAP_EN
   localparam st_t UNSUP = HALT;
`else
   localparam st_t UNSUP = FETCH;
   assign illegal = 1'b0;
`endif
   always_comb begin
      nx = st;
      case (st)
         FETCH:  nx = mif.mem_ready ? DECODE : FETCH;
         DECODE: nx = op == 6'h00 ? EXEC :
                      (op == 6'h23 || op == 6'h2b) ? MEMADR :
                      op == 6'h04 ? BRANCH :
                      op == 6'h08 ? ADDIEX :
                      op == 6'h02 ? JUMP : UNSUP;
         MEMADR: nx = op == 6'h2b ? MEMWR : MEMRD;
         MEMRD:  nx = mif.mem_ready ? MEMWB : MEMRD;
         MEMWR:  nx = mif.mem_ready ? FETCH : MEMWR;
         EXEC:   nx = ALUWB;
         ADDIEX: nx = ADDIWB;
         MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: nx = FETCH;
         default: nx = st;
      endcase
   end
   // Reset decodes as HALT, whose outputs are all zero, so every control is forced low
   always_comb begin
      mreq = 1'b0;
      mwr = 1'b0;
      io = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      branch = 1'b0;
      pc_src = 2'b00;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      alu_op = 2'b00;
      reg_dst = 1'b0;
      mem_to_reg = 1'b0;
      reg_write = 1'b0;
      case (rst_n ? st : HALT)
         FETCH: begin
            mreq = 1'b1;
            alu_src_b = 2'b01;
            ir_write = mif.mem_ready;
            pc_write = mif.mem_ready;
         end
         DECODE: alu_src_b = 2'b11;
         MEMADR, ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEMRD: begin
            mreq = 1'b1;
            io = 1'b1;
         end
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write = 1'b1;
         end
         MEMWR: begin
            mreq = 1'b1;
            mwr = 1'b1;
            io = 1'b1;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_op = 2'b10;
         end
         ALUWB: begin
            reg_dst = 1'b1;
            reg_write = 1'b1;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            alu_op = 2'b01;
            pc_src = 2'b01;
            branch = 1'b1;
         end
         ADDIWB: reg_write = 1'b1;
         JUMP: begin
            pc_src = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end
   assign pc_en = pc_write | (branch & zero);
   assign mif.mem_req = mreq;
   assign mif.mem_write = mwr;
   assign mif.iord = io;
   assign state = st;
   // Only completion states (and DECODE for a NOP) ever move into FETCH from elsewhere
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st <= FETCH;
         retired <= '0;
`ifdef MC_CU_ILLEGAL_TRAP_EN
         illegal <= 1'b0;
`endif
      end else begin
         st <= nx;
         if (nx == FETCH && st != FETCH) retired <= retired + CNT_W'(1);
`ifdef MC_CU_ILLEGAL_TRAP_EN
         illegal <= nx == HALT;
`endif
      end
   end
endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: directed scoreboard bench for mc_cu; a 2-bit-counter copy checks retired wrap
module tb_mc_cu;
   typedef struct packed {
      logic [3:0]  st;
      logic [14:0] ctl;
      logic [31:0] ret;
      logic [1:0]  ret2;
      logic        ill;
   } exp_t;
   logic clk = 1'b0, rst_n, zero;
   logic [5:0] op;
   logic ir_write, pc_en, alu_src_a, reg_dst, mem_to_reg, reg_write, illegal;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic [3:0] state;
   logic [31:0] retired;
   logic ir_write2, pc_en2, alu_src_a2, reg_dst2, mem_to_reg2, reg_write2, illegal2;
   logic [1:0] pc_src2, alu_src_b2, alu_op2, retired2;
   logic [3:0] state2;
   exp_t q[$];
   int errs = 0, checks = 0, er = 0;
   mc_cu_if mif();
   mc_cu_if mif2();
   assign mif2.mem_ready = mif.mem_ready;
   always #5 clk = ~clk;
   mc_cu #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mif(mif),
      .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .state(state), .retired(retired), .illegal(illegal)
   );
   mc_cu #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mif(mif2),
      .ir_write(ir_write2), .pc_en(pc_en2), .pc_src(pc_src2), .alu_src_a(alu_src_a2),
      .alu_src_b(alu_src_b2), .alu_op(alu_op2), .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2),
      .reg_write(reg_write2), .state(state2), .retired(retired2), .illegal(illegal2)
   );
   // {mem_req,mem_write,iord,ir_write,pc_en,pc_src,alu_src_a,alu_src_b,alu_op,reg_dst,mem_to_reg,reg_write}
   function automatic logic [14:0] ctl(input logic [3:0] s, input logic mr, input logic z);
      ctl = '0;
      case (s)
         4'd0:  ctl = {1'b1, 1'b0, 1'b0, mr, mr, 2'b00, 1'b0, 2'b01, 2'b00, 3'b000};
         4'd1:  ctl = {5'b0, 2'b00, 1'b0, 2'b11, 2'b00, 3'b000};
         4'd2:  ctl = {5'b0, 2'b00, 1'b1, 2'b10, 2'b00, 3'b000};
         4'd3:  ctl = {3'b101, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000};
         4'd4:  ctl = {5'b0, 2'b00, 1'b0, 2'b00, 2'b00, 3'b011};
         4'd5:  ctl = {3'b111, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000};
         4'd6:  ctl = {5'b0, 2'b00, 1'b1, 2'b00, 2'b10, 3'b000};
         4'd7:  ctl = {5'b0, 2'b00, 1'b0, 2'b00, 2'b00, 3'b101};
         4'd8:  ctl = {4'b0, z, 2'b01, 1'b1, 2'b00, 2'b01, 3'b000};
         4'd9:  ctl = {5'b0, 2'b00, 1'b1, 2'b10, 2'b00, 3'b000};
         4'd10: ctl = {5'b0, 2'b00, 1'b0, 2'b00, 2'b00, 3'b001};
         4'd11: ctl = {4'b0, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 3'b000};
         default: ctl = '0;
      endcase
   endfunction
   task automatic step(input string tag, input logic [3:0] s);
      exp_t e, g;
      e.st = s;
      e.ctl = rst_n ? ctl(s, mif.mem_ready, zero) : 15'd0;
      e.ret = er;
      e.ret2 = er[1:0];
      e.ill = s == 4'd12;
      q.push_back(e);
      @(negedge clk);
      g = {state, mif.mem_req, mif.mem_write, mif.iord, ir_write, pc_en, pc_src, alu_src_a,
           alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, retired, retired2, illegal};
      e = q.pop_front();
      checks++;
      assert (g === e) else begin
         errs++;
         $error("FAIL %s: got st=%0d ctl=%b ret=%0d ret2=%0d ill=%b, exp st=%0d ctl=%b ret=%0d ret2=%0d ill=%b",
                tag, g.st, g.ctl, g.ret, g.ret2, g.ill, e.st, e.ctl, e.ret, e.ret2, e.ill);
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst_n = 1'b0;
      op = 6'h00;
      zero = 1'b0;
      mif.mem_ready = 1'b1;
      #1;
      step("reset0", 0);
      step("reset1", 0);
      rst_n = 1'b1;
      step("r_fetch", 0); step("r_dec", 1); step("r_exec", 6); step("r_wb", 7);
      er++;
      op = 6'h23;
      step("lw_fetch", 0); step("lw_dec", 1); step("lw_adr", 2);
      mif.mem_ready = 1'b0;
      step("lw_rd_wait0", 3); step("lw_rd_wait1", 3);
      mif.mem_ready = 1'b1;
      step("lw_rd", 3); step("lw_wb", 4);
      er++;
      mif.mem_ready = 1'b0;
      step("fetch_stall", 0);
      mif.mem_ready = 1'b1;
      op = 6'h04;
      zero = 1'b1;
      step("beq1_fetch", 0); step("beq1_dec", 1); step("beq1_br", 8);
      er++;
      zero = 1'b0;
      step("beq0_fetch", 0); step("beq0_dec", 1); step("beq0_br", 8);
      er++;
      op = 6'h02;
      step("j_fetch", 0); step("j_dec", 1); step("j_jump", 11);
      er++;
      op = 6'h2b;
      step("sw_fetch", 0); step("sw_dec", 1); step("sw_adr", 2);
      mif.mem_ready = 1'b0;
      step("sw_wr_wait", 5);
      mif.mem_ready = 1'b1;
      step("sw_wr", 5);
      er++;
      op = 6'h08;
      step("addi_fetch", 0); step("addi_dec", 1); step("addi_ex", 9); step("addi_wb", 10);
      er++;
      op = 6'h3f;
      step("ill_fetch", 0); step("ill_dec", 1);
`ifdef MC_CU_ILLEGAL_TRAP_EN
      repeat (10) step("ill_halt", 12);
      rst_n = 1'b0;
      er = 0;
      step("ill_reset", 0);
      rst_n = 1'b1;
`else
      er++;
`endif
      op = 6'h2b;
      step("swr_fetch", 0); step("swr_dec", 1); step("swr_adr", 2);
      mif.mem_ready = 1'b0;
      step("swr_wait", 5);
      rst_n = 1'b0;
      er = 0;
      step("swr_abort", 0);
      rst_n = 1'b1;
      mif.mem_ready = 1'b1;
      op = 6'h00;
      step("post_fetch", 0); step("post_dec", 1); step("post_exec", 6); step("post_wb", 7);
      er++;
      step("post_done", 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/mc_cu.md
# mc_cu

Multicycle control unit for the MIPS datapath: a Moore/Mealy state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It drives the shared ALU, single instruction/data memory port, register file and PC muxes, and stalls on a memory-ready handshake. It replaces the one-cycle combinational control path when the core is built as a multicycle machine.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  instruction[31:26] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  access is a write
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- ir_write  out  1  load instruction register
- pc_en  out  1  PC load enable = pc_write | (branch & zero)
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2
- alu_op  out  2  00 add, 01 sub, 10 decode funct
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data reg
- reg_write  out  1  register file write
- state  out  4  current state encoding
- retired  out  CNT_W  completed-instruction count
- illegal  out  1  unsupported opcode trapped (see Configuration)

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=12.
- Any output not listed for a state is 0.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_en are 1 only when mem_ready=1. The FSM moves to DECODE on mem_ready; otherwise it stays in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target computed in advance). Next state by op:
  - 0x00 → EXEC
  - 0x23 / 0x2B → MEMADR
  - 0x04 → BRANCH
  - 0x08 → ADDIEX
  - 0x02 → JUMP
  - other opcodes → see Configuration
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Both are held stable through the wait. On mem_ready the FSM goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, then ALUWB.
- ALUWB: reg_dst=1, reg_write=1, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. Internal branch=1, so pc_en=zero. Then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00, then ADDIWB.
- ADDIWB: reg_dst=0, reg_write=1, then FETCH.
- JUMP: pc_src=10, pc_en=1, then FETCH.
- retired increments by 1 on every transition into FETCH from a completion state (MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP). It wraps from all-ones to 0.
- mem_ready is ignored in non-memory states.

## Timing
- State register, retired and illegal are flopped. All other outputs are combinational from state, op, zero and mem_ready.
- With mem_ready tied to 1, cycles per instruction are: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- While rst_n=0: state=FETCH (0), retired=0, illegal=0, and all outputs are forced to 0, including mem_req.
- The first cycle after release is a normal FETCH.
- Reset asserted mid-instruction aborts it immediately. No partial write-back occurs and retired is not incremented.

## Configuration
- MC_CU_ILLEGAL_TRAP_EN defined: an unsupported op in DECODE moves the FSM to HALT. In HALT, illegal=1 and all enables are 0. HALT is exited only by reset, and retired does not increment.
- MC_CU_ILLEGAL_TRAP_EN undefined: an unsupported op is treated as NOP. DECODE goes directly to FETCH and retired increments. illegal is tied to 0 and the HALT state is unreachable.

## Test plan
- Reset then mem_ready=1, op=0x00 → states 0,1,6,7,0; reg_write=1 and reg_dst=1 in state 7; retired=1.
- lw (op=0x23) with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0 (7 cycles); mem_req=1 and iord=1 throughout MEMRD.
- beq (op=0x04) with zero=1, then again with zero=0 → pc_en=1 in BRANCH for the first and 0 for the second; pc_src=01 in both; retired=2.
- j (op=0x02) → pc_en=1 with pc_src=10 in state 11; 3 cycles total. Separately, preload retired to 0xFFFFFFFF; the next completion wraps it to 0.
- rst_n pulsed low during MEMWR → outputs 0 immediately, state=0, retired=0, no mem_write after release until a new sw.
- op=0x3F: with MC_CU_ILLEGAL_TRAP_EN, state stays 12 and illegal=1 for 10 cycles. Without it, the FSM returns to 0 after DECODE and retired increments.
